// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive path: parity modes, rx FSM states, error tag bits.
package uart_pkg;
  localparam int OVS = 16;

  localparam int ERR_PAR = 0;
  localparam int ERR_FRM = 1;
  localparam int ERR_BRK = 2;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'd0,
    PAR_EVEN  = 2'd1,
    PAR_ODD   = 2'd2,
    PAR_NONE3 = 2'd3
  } par_mode_e;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } rx_state_e;

  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_b);
    if (req < 4'd5)       return 4'd5;
    else if (req > max_b) return max_b;
    else                  return req;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO; head is presented combinationally, zero when empty.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_level;
  logic             w_pop, w_push;

  assign empty  = (r_level == '0);
  assign full   = (r_level == (AW+1)'(DEPTH));
  assign w_pop  = pop & ~empty;
  // a full FIFO still accepts when the head leaves in the same cycle
  assign w_push = push & (~full | w_pop);
  assign dout   = empty ? '0 : r_mem[r_rptr];
  assign level  = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_stream.sv
// 16x oversampled UART receiver with runtime frame config, error tagging, FIFO and
// valid/ready output; irq on FIFO threshold or idle timeout.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int IRQ_THRESH   = 8,
  parameter int TIMEOUT_BITS = 32,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rx,
  input  logic                          rx_en,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [3:0]                    data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [2:0]                    m_err,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  output logic                          irq
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = DATA_WIDTH + 3;
  localparam int TW = $clog2(TIMEOUT_BITS + 1);
  localparam logic [3:0] LAST = 4'(OVS - 1);

  logic                  r_rx_s1, r_rx_s2, r_rx_d;
  logic [DIV_WIDTH-1:0]  r_div, r_pre;
  logic [3:0]            r_dbits, r_samp, r_bitcnt;
  par_mode_e             r_par;
  logic                  r_stop2, r_stopn;
  rx_state_e             r_state;
  logic [2:0]            r_smp;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_acc, r_pbit, r_perr, r_ferr;
  logic                  r_push, r_overrun, r_to_flag;
  logic [EW-1:0]         r_push_ent;
  logic [3:0]            r_to_tick;
  logic [TW-1:0]         r_to_bits;

  logic [DIV_WIDTH-1:0]  w_div;
  logic                  w_tick, w_fall, w_maj, w_par_en, w_ferr_fin, w_brk;
  logic                  w_full, w_empty, w_pop;
  logic [EW-1:0]         w_dout;
  logic [LW-1:0]         w_level;

  assign w_div      = (r_div == '0) ? DIV_WIDTH'(1) : r_div;
  assign w_tick     = (r_pre >= w_div - 1'b1);
  assign w_fall     = r_rx_d & ~r_rx_s2;
  assign w_maj      = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
  assign w_par_en   = (r_par == PAR_EVEN) | (r_par == PAR_ODD);
  assign w_ferr_fin = r_ferr | ~r_rx_s2;
  assign w_brk      = w_ferr_fin & (r_shift == '0) & (~w_par_en | ~r_pbit);
  assign w_pop      = m_valid & m_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
      r_div   <= DIV_WIDTH'(1);
      r_dbits <= clamp_bits(4'd8, 4'(DATA_WIDTH));
      r_par   <= PAR_NONE;
      r_stop2 <= 1'b0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
      // config is only captured while the receiver is disabled
      if (!rx_en) begin
        r_div   <= baud_div;
        r_dbits <= clamp_bits(data_bits, 4'(DATA_WIDTH));
        r_par   <= par_mode_e'(parity_mode);
        r_stop2 <= stop2;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_pre      <= '0;
      r_samp     <= '0;
      r_smp      <= '0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_acc      <= 1'b0;
      r_pbit     <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_stopn    <= 1'b0;
      r_push     <= 1'b0;
      r_push_ent <= '0;
    end else begin
      r_push <= 1'b0;
      r_pre  <= w_tick ? '0 : r_pre + 1'b1;
      if (!rx_en) begin
        r_state <= S_IDLE;
      end else if (r_state == S_IDLE) begin
        if (w_fall) begin
          r_state  <= S_START;
          r_pre    <= '0;
          r_samp   <= '0;
          r_bitcnt <= '0;
          r_shift  <= '0;
          r_acc    <= 1'b0;
          r_pbit   <= 1'b0;
          r_perr   <= 1'b0;
          r_ferr   <= 1'b0;
          r_stopn  <= 1'b0;
        end
      end else if (w_tick) begin
        r_samp <= r_samp + 1'b1;
        case (r_samp)
          4'd7:    r_smp[0] <= r_rx_s2;
          4'd8:    r_smp[1] <= r_rx_s2;
          4'd9:    r_smp[2] <= r_rx_s2;
          default: ;
        endcase
        case (r_state)
          S_START: if (r_samp == LAST) r_state <= w_maj ? S_IDLE : S_DATA;
          S_DATA: if (r_samp == LAST) begin
            r_shift  <= r_shift | (DATA_WIDTH'(w_maj) << r_bitcnt);
            r_acc    <= r_acc ^ w_maj;
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == r_dbits - 4'd1) r_state <= w_par_en ? S_PARITY : S_STOP;
          end
          S_PARITY: if (r_samp == LAST) begin
            r_pbit  <= w_maj;
            r_perr  <= (r_acc ^ w_maj) != (r_par == PAR_ODD);
            r_state <= S_STOP;
          end
          S_STOP: if (r_samp == 4'd8) begin
            if (!r_rx_s2) r_ferr <= 1'b1;
            // leave at mid stop bit so the next start edge is never missed
            if (r_stopn == r_stop2) begin
              r_push     <= 1'b1;
              r_push_ent <= {w_brk, w_ferr_fin, r_perr, r_shift};
              r_state    <= S_IDLE;
            end
          end else if (r_samp == LAST) begin
            r_stopn <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overrun <= 1'b0;
      r_to_tick <= '0;
      r_to_bits <= '0;
      r_to_flag <= 1'b0;
    end else begin
      r_overrun <= r_push & w_full & ~w_pop;
      if (r_push | w_pop | w_empty) begin
        r_to_tick <= '0;
        r_to_bits <= '0;
        if (r_push | w_pop) r_to_flag <= 1'b0;
      end else if (r_state == S_IDLE && w_tick) begin
        r_to_tick <= r_to_tick + 1'b1;
        if (r_to_tick == LAST && !r_to_flag) begin
          if (r_to_bits == TW'(TIMEOUT_BITS - 1)) r_to_flag <= 1'b1;
          else                                     r_to_bits <= r_to_bits + 1'b1;
        end
      end
    end
  end

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (r_push),
    .din   (r_push_ent),
    .pop   (w_pop),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  assign m_valid = ~w_empty;
  assign m_data  = w_dout[DATA_WIDTH-1:0];
  assign m_err   = w_dout[EW-1:DATA_WIDTH];
  assign level   = w_level;
  assign overrun = r_overrun;
  assign irq     = (w_level >= LW'(IRQ_THRESH)) | r_to_flag;
endmodule

// File: tb/tb_uart_rx_stream.sv
// Bench for uart_rx_stream: directed frame table, random frames vs a frame-level model,
// and hand sequences for overrun, timeout, reset and enable corner cases.
module tb_uart_rx_stream;
  logic        clk = 1'b0;
  logic        rstn, rx, rx_en, stop2, m_ready;
  logic [15:0] baud_div;
  logic [3:0]  data_bits;
  logic [1:0]  parity_mode;
  logic        m_valid, overrun, irq;
  logic [7:0]  m_data;
  logic [2:0]  m_err;
  logic [4:0]  level;

  int errs = 0, checks = 0, ovr_cnt = 0, cur_div = 1;
  logic [10:0] got_q[$];
  logic [10:0] exp_q[$];

  uart_rx_stream dut (
    .clk(clk), .rstn(rstn), .rx(rx), .rx_en(rx_en), .baud_div(baud_div),
    .data_bits(data_bits), .parity_mode(parity_mode), .stop2(stop2),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err),
    .level(level), .overrun(overrun), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn) begin
      if (m_valid && m_ready) got_q.push_back({m_err, m_data});
      if (overrun) ovr_cnt++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tk(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int eff_bits(input int f);
    return (f < 5) ? 5 : (f > 8) ? 8 : f;
  endfunction

  task automatic set_cfg(input int div, input int field, input int pm, input bit two);
    rx_en = 1'b0;
    tk(2);
    baud_div = 16'(div); data_bits = 4'(field); parity_mode = 2'(pm); stop2 = two;
    cur_div = (div == 0) ? 1 : div;
    tk(2);
    rx_en = 1'b1;
    tk(2);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input int pm,
                            input bit flip, input bit st1, input bit st2, input bit two);
    int  bt;
    logic p;
    bt = 16 * cur_div;
    p  = 1'b0;
    rx = 1'b0; tk(bt);
    for (int i = 0; i < nb; i++) begin
      rx = d[i]; p = p ^ d[i]; tk(bt);
    end
    if (pm == 1 || pm == 2) begin
      rx = p ^ (pm == 2) ^ flip; tk(bt);
    end
    rx = st1; tk(bt);
    if (two) begin rx = st2; tk(bt); end
    rx = 1'b1;
  endtask

  // frame-level expectation: what the receiver should tag for the bits put on the wire
  function automatic logic [10:0] model(input logic [7:0] d, input int nb, input int pm,
                                        input bit flip, input bit st1, input bit st2, input bit two);
    logic [7:0] dm;
    bit pen, pbit, perr, ferr, brk;
    dm   = d & 8'((1 << nb) - 1);
    pen  = (pm == 1 || pm == 2);
    pbit = (^dm) ^ (pm == 2) ^ flip;
    perr = pen & flip;
    ferr = !st1 || (two && !st2);
    brk  = ferr && (dm == 0) && (!pen || !pbit);
    return {brk, ferr, perr, dm};
  endfunction

  task automatic expect_one(input string name, input logic [10:0] exp);
    chk({name, "_cnt"}, got_q.size(), 1);
    if (got_q.size() > 0) chk(name, got_q[0], exp);
    got_q.delete();
  endtask

  typedef struct {
    int div; int field; int pm; bit two; bit flip; bit st1; bit st2;
    logic [7:0] d; logic [10:0] exp;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{4, 8, 0, 0, 0, 1, 1, 8'hA5, 11'h0A5};
    tbl[1] = '{4, 7, 1, 0, 1, 1, 1, 8'h55, 11'h155};
    tbl[2] = '{4, 8, 0, 1, 0, 1, 0, 8'h3C, 11'h23C};
    tbl[3] = '{4, 8, 2, 0, 0, 1, 1, 8'h00, 11'h000};
    tbl[4] = '{4, 5, 2, 0, 0, 1, 1, 8'h1F, 11'h01F};
    tbl[5] = '{4, 9, 0, 0, 0, 1, 1, 8'hFF, 11'h0FF};
    tbl[6] = '{4, 3, 0, 0, 0, 1, 1, 8'hF3, 11'h013};
    tbl[7] = '{4, 8, 1, 0, 0, 0, 1, 8'h00, 11'h600};
    tbl[8] = '{4, 8, 1, 0, 1, 0, 1, 8'h00, 11'h300};
    tbl[9] = '{0, 6, 3, 0, 0, 1, 1, 8'h81, 11'h001};

    rstn = 1'b0; rx = 1'b1; rx_en = 1'b0; m_ready = 1'b1; stop2 = 1'b0;
    baud_div = 16'd4; data_bits = 4'd8; parity_mode = 2'd0;
    tk(3);
    chk("rst_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_irq", irq, 0);
    chk("rst_data", m_data, 0);
    chk("rst_err", m_err, 0);
    chk("rst_ovr", overrun, 0);
    rstn = 1'b1;
    tk(2);

    for (int v = 0; v < 10; v++) begin
      set_cfg(tbl[v].div, tbl[v].field, tbl[v].pm, tbl[v].two);
      send_frame(tbl[v].d, eff_bits(tbl[v].field), tbl[v].pm, tbl[v].flip,
                 tbl[v].st1, tbl[v].st2, tbl[v].two);
      tk(32 * cur_div);
      if (v == 0) chk("irq_single", irq, 0);
      expect_one($sformatf("vec%0d", v), tbl[v].exp);
    end

    // whole frame of line-low: break plus framing
    set_cfg(4, 8, 0, 0);
    rx = 1'b0; tk(640); rx = 1'b1; tk(128);
    expect_one("break", 11'h600);

    // short low glitch while idle
    rx = 1'b0; tk(12); rx = 1'b1; tk(192);
    chk("glitch_cnt", got_q.size(), 0);
    chk("glitch_level", level, 0);

    // random frames against the model
    for (int n = 0; n < 16; n++) begin
      int div, field, pm, nb;
      bit two, flip, st1, st2;
      logic [7:0] d;
      div = $urandom_range(3); field = $urandom_range(15); pm = $urandom_range(3);
      two = 1'($urandom_range(1)); flip = ($urandom_range(3) == 0);
      st1 = ($urandom_range(5) != 0); st2 = ($urandom_range(5) != 0);
      d = 8'($urandom_range(255));
      nb = eff_bits(field);
      set_cfg(div, field, pm, two);
      send_frame(d, nb, pm, flip, st1, st2, two);
      exp_q.push_back(model(d, nb, pm, flip, st1, st2, two));
      tk(32 * cur_div);
    end
    chk("rand_cnt", got_q.size(), exp_q.size());
    for (int k = 0; k < 16; k++)
      if (k < got_q.size()) chk($sformatf("rand%0d", k), got_q[k], exp_q[k]);
    got_q.delete();

    // fill past full: threshold irq, one overrun, in-order drain
    set_cfg(4, 8, 0, 0);
    m_ready = 1'b0; ovr_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 8, 0, 0, 1, 1, 0);
      tk(4);
      chk($sformatf("fill_level%0d", i), level, (i + 1 > 16) ? 16 : i + 1);
      chk($sformatf("fill_irq%0d", i), irq, (i >= 7));
    end
    chk("overrun_cnt", ovr_cnt, 1);
    m_ready = 1'b1;
    tk(40);
    chk("drain_cnt", got_q.size(), 16);
    for (int k = 0; k < 16; k++)
      if (k < got_q.size()) chk($sformatf("drain%0d", k), got_q[k], k);
    got_q.delete();

    // idle timeout with a partly filled FIFO
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(8'h40 + 8'(i), 8, 0, 0, 1, 1, 0);
    tk(4);
    chk("to_irq_lvl", irq, 0);
    tk(30 * 64);
    chk("to_early", irq, 0);
    tk(4 * 64);
    chk("to_fire", irq, 1);
    chk("to_level", level, 3);
    m_ready = 1'b1; tk(1); m_ready = 1'b0; tk(2);
    chk("to_pop_irq", irq, 0);
    chk("to_pop_level", level, 2);
    expect_one("to_pop_data", 11'h040);
    m_ready = 1'b1; tk(10);
    got_q.delete();

    // async reset in the middle of a data bit with an entry queued
    m_ready = 1'b0;
    send_frame(8'h11, 8, 0, 0, 1, 1, 0);
    rx = 1'b0; tk(64); rx = 1'b1; tk(64); rx = 1'b0; tk(32);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_data", m_data, 0);
    rx = 1'b1; rx_en = 1'b0;
    tk(3);
    rstn = 1'b1;
    tk(2);
    set_cfg(4, 8, 0, 0);
    m_ready = 1'b1;
    send_frame(8'h3C, 8, 0, 0, 1, 1, 0);
    tk(128);
    expect_one("post_rst", 11'h03C);

    // disable mid-frame: partial frame must be dropped
    rx = 1'b0; tk(64); rx = 1'b1; tk(256);
    rx_en = 1'b0; tk(2); rx_en = 1'b1;
    tk(512);
    chk("en_drop_cnt", got_q.size(), 0);
    chk("en_drop_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
